// File: rtl/cpu_pkg.sv
// cpu_pkg: sequencer op codes and FSM state encoding
package cpu_pkg;
  localparam logic [2:0] SEQ_INC  = 3'd0;
  localparam logic [2:0] SEQ_JMP  = 3'd1;
  localparam logic [2:0] SEQ_BRR  = 3'd2;
  localparam logic [2:0] SEQ_CALL = 3'd3;
  localparam logic [2:0] SEQ_RET  = 3'd4;
  localparam logic [2:0] SEQ_HALT = 3'd5;
  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_HALT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;
endpackage

// File: rtl/pc_return_stack.sv
// pc_return_stack: registered LIFO of return addresses; push-when-full and pop-when-empty are ignored
module pc_return_stack #(
  parameter int DEPTH = 4,
  parameter int W = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_N = CW'(DEPTH);
  logic [W-1:0] mem [2**AW];
  logic [CW-1:0] top;
  assign top = count - 1'b1;
  assign dout = mem[top[AW-1:0]];
  assign full = count == FULL_N;
  assign empty = count == '0;
  // memory is deliberately not cleared on reset; only the count is
  always_ff @(posedge clk) begin
    if (reset) count <= '0;
    else if (push && !full) begin
      mem[count[AW-1:0]] <= din;
      count <= count + 1'b1;
    end else if (pop && !empty) count <= count - 1'b1;
  end
endmodule

// File: rtl/program_sequencer.sv
// program_sequencer: fetch-path PC with jumps, relative branches, return stack and RUN/HALT/FAULT control
module program_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W = 4,
  parameter int STACK_DEPTH = 4,
  parameter int RESET_VEC = 0,
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [2:0]      op,
  input  logic            cond,
  input  logic [PC_W-1:0] target,
  input  logic            resume,
  output logic [PC_W-1:0] pc_out,
  output logic            halted,
  output logic            fault,
  output logic [SP_W-1:0] sp_out
);
  logic [1:0] state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt, inc, rel, top;
  logic full, empty, push, pop, act;
  assign act = state == ST_RUN && en;
  assign push = act && op == SEQ_CALL && !full;
  assign pop = act && op == SEQ_RET && !empty;
  assign inc = pc + 1'b1;
  // offset is two's complement; modulo-2**PC_W addition makes sign extension implicit
  assign rel = pc + target;
  pc_return_stack #(.DEPTH(STACK_DEPTH), .W(PC_W)) u_stack (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .din(inc),
    .dout(top), .count(sp_out), .full(full), .empty(empty)
  );
  always_comb begin
    pc_nxt = pc;
    state_nxt = state;
    if (state == ST_HALT) state_nxt = resume ? ST_RUN : ST_HALT;
    else if (act) begin
      case (op)
        SEQ_JMP:  pc_nxt = cond ? target : inc;
        SEQ_BRR:  pc_nxt = cond ? rel : inc;
        SEQ_CALL: begin
          pc_nxt = full ? pc : target;
          state_nxt = full ? ST_FAULT : ST_RUN;
        end
        SEQ_RET:  begin
          pc_nxt = empty ? pc : top;
          state_nxt = empty ? ST_FAULT : ST_RUN;
        end
        SEQ_HALT: state_nxt = ST_HALT;
        default:  pc_nxt = inc;
      endcase
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= PC_W'(RESET_VEC);
      state <= ST_RUN;
    end else begin
      pc <= pc_nxt;
      state <= state_nxt;
    end
  end
  assign pc_out = pc;
  assign halted = state == ST_HALT;
  assign fault = state == ST_FAULT;
endmodule

// File: tb/tb_program_sequencer.sv
// tb_program_sequencer: directed and randomized checks against a behavioural PC/stack model
module tb_program_sequencer;
  logic clk = 0, reset = 1, en = 0, cond = 0, resume = 0;
  logic [2:0] op = 0;
  logic [3:0] target = 0;
  logic [3:0] pc_out;
  logic halted, fault;
  logic [2:0] sp_out;
  int checks = 0, failures = 0;
  int m_pc = 0, m_mode = 0;
  int m_stk[$];
  wire [8:0] obs = {pc_out, sp_out, halted, fault};

  program_sequencer #(.PC_W(4), .STACK_DEPTH(4), .RESET_VEC(0)) dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .cond(cond), .target(target),
    .resume(resume), .pc_out(pc_out), .halted(halted), .fault(fault), .sp_out(sp_out)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] mexp();
    return {4'(m_pc), 3'(m_stk.size()), m_mode == 1, m_mode == 2};
  endfunction

  task automatic drive(input logic rs, input logic e, input logic [2:0] o,
                       input logic c, input logic [3:0] t, input logic r);
    int off;
    reset = rs; en = e; op = o; cond = c; target = t; resume = r;
    @(posedge clk);
    if (rs) begin
      m_pc = 0; m_mode = 0; m_stk.delete();
    end else if (m_mode == 1) begin
      if (r) m_mode = 0;
    end else if (m_mode == 0 && e) begin
      off = t >= 8 ? int'(t) - 16 : int'(t);
      case (o)
        3'd1: m_pc = c ? int'(t) : (m_pc + 1) % 16;
        3'd2: m_pc = c ? (m_pc + off + 16) % 16 : (m_pc + 1) % 16;
        3'd3: if (m_stk.size() == 4) m_mode = 2;
              else begin m_stk.push_back((m_pc + 1) % 16); m_pc = int'(t); end
        3'd4: if (m_stk.size() == 0) m_mode = 2;
              else m_pc = m_stk.pop_back();
        3'd5: m_mode = 1;
        default: m_pc = (m_pc + 1) % 16;
      endcase
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 3'd3, 1, 4'd9, 1);
    checks++;
    if (obs !== 9'h000) begin failures++; $display("FAIL reset got=%h exp=%h", obs, 9'h000); end
  endtask

  task automatic test_inc_wrap();
    for (int i = 0; i < 20; i++) begin
      drive(0, 1, 3'd0, 0, 4'($urandom), 0);
      checks++;
      if (obs !== mexp() || pc_out !== 4'((i + 1) % 16)) begin
        failures++; $display("FAIL inc_wrap step=%0d got=%h exp=%h", i, obs, mexp());
      end
    end
  endtask

  task automatic test_jump_branch();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 1, 3'd0, 0, 0, 0);
    drive(0, 1, 3'd1, 0, 4'd9, 0);
    checks++;
    if (pc_out !== 4'd6 || obs !== mexp()) begin failures++; $display("FAIL jmp_nottaken got=%h exp=6", pc_out); end
    drive(0, 1, 3'd1, 1, 4'd9, 0);
    checks++;
    if (pc_out !== 4'd9 || obs !== mexp()) begin failures++; $display("FAIL jmp_taken got=%h exp=9", pc_out); end
    drive(0, 1, 3'd2, 1, 4'hE, 0);
    checks++;
    if (pc_out !== 4'd7 || obs !== mexp()) begin failures++; $display("FAIL brr_back got=%h exp=7", pc_out); end
    drive(0, 1, 3'd2, 0, 4'h3, 0);
    checks++;
    if (pc_out !== 4'd8 || obs !== mexp()) begin failures++; $display("FAIL brr_nottaken got=%h exp=8", pc_out); end
  endtask

  task automatic test_call_ret();
    logic [7:0] exp_t [4] = '{8'h81, 8'hC2, 8'h91, 8'h30};
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 3'd0, 0, 0, 0);
    drive(0, 1, 3'd0, 0, 0, 0);
    drive(0, 1, 3'd3, 0, 4'd8, 0);
    checks++;
    if ({pc_out, 4'(sp_out)} !== exp_t[0] || obs !== mexp()) begin failures++; $display("FAIL call1 got=%h exp=%h", {pc_out, 4'(sp_out)}, exp_t[0]); end
    drive(0, 1, 3'd3, 0, 4'd12, 0);
    checks++;
    if ({pc_out, 4'(sp_out)} !== exp_t[1] || obs !== mexp()) begin failures++; $display("FAIL call2 got=%h exp=%h", {pc_out, 4'(sp_out)}, exp_t[1]); end
    drive(0, 1, 3'd4, 0, 0, 0);
    checks++;
    if ({pc_out, 4'(sp_out)} !== exp_t[2] || obs !== mexp()) begin failures++; $display("FAIL ret1 got=%h exp=%h", {pc_out, 4'(sp_out)}, exp_t[2]); end
    drive(0, 1, 3'd4, 0, 0, 0);
    checks++;
    if ({pc_out, 4'(sp_out)} !== exp_t[3] || obs !== mexp()) begin failures++; $display("FAIL ret2 got=%h exp=%h", {pc_out, 4'(sp_out)}, exp_t[3]); end
  endtask

  task automatic test_overflow();
    logic [3:0] held;
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 3'd3, 0, 4'($urandom), 0);
    checks++;
    if (sp_out !== 3'd4 || fault !== 1'b0 || obs !== mexp()) begin failures++; $display("FAIL fill got=%h exp=%h", obs, mexp()); end
    held = pc_out;
    drive(0, 1, 3'd3, 0, 4'($urandom), 0);
    checks++;
    if (fault !== 1'b1 || pc_out !== held || sp_out !== 3'd4 || obs !== mexp()) begin failures++; $display("FAIL overflow got=%h exp=%h", obs, mexp()); end
    drive(0, 1, 3'd0, 0, 0, 1);
    drive(0, 1, 3'd4, 1, 0, 1);
    checks++;
    if (fault !== 1'b1 || halted !== 1'b0 || pc_out !== held || obs !== mexp()) begin failures++; $display("FAIL fault_hold got=%h exp=%h", obs, mexp()); end
    drive(1, 0, 0, 0, 0, 0);
    checks++;
    if (obs !== 9'h000) begin failures++; $display("FAIL fault_reset got=%h exp=%h", obs, 9'h000); end
  endtask

  task automatic test_underflow();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 3'd0, 0, 0, 0);
    drive(0, 1, 3'd4, 0, 0, 0);
    checks++;
    if (fault !== 1'b1 || pc_out !== 4'd3 || sp_out !== 3'd0 || obs !== mexp()) begin failures++; $display("FAIL underflow got=%h exp=%h", obs, mexp()); end
  endtask

  task automatic test_halt();
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 1, 3'd0, 0, 0, 0);
    drive(0, 1, 3'd5, 0, 0, 1);
    checks++;
    if (halted !== 1'b1 || pc_out !== 4'd6 || obs !== mexp()) begin failures++; $display("FAIL halt_enter got=%h exp=%h", obs, mexp()); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 3'd0, 0, 0, 0);
      checks++;
      if (halted !== 1'b1 || pc_out !== 4'd6 || obs !== mexp()) begin failures++; $display("FAIL halt_hold step=%0d got=%h exp=%h", i, obs, mexp()); end
    end
    drive(0, 0, 3'd0, 0, 0, 1);
    checks++;
    if (halted !== 1'b0 || pc_out !== 4'd6 || obs !== mexp()) begin failures++; $display("FAIL resume got=%h exp=%h", obs, mexp()); end
    drive(0, 1, 3'd0, 0, 0, 0);
    checks++;
    if (pc_out !== 4'd7 || obs !== mexp()) begin failures++; $display("FAIL after_resume got=%h exp=7", pc_out); end
    drive(0, 1, 3'd5, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 1);
    checks++;
    if (obs !== 9'h000) begin failures++; $display("FAIL halt_reset got=%h exp=%h", obs, 9'h000); end
  endtask

  task automatic test_random();
    logic rs, e;
    for (int i = 0; i < 600; i++) begin
      rs = $urandom_range(0, 39) == 0;
      e = $urandom_range(0, 4) != 0;
      drive(rs, e, 3'($urandom), 1'($urandom), 4'($urandom), $urandom_range(0, 3) == 0);
      checks++;
      if (obs !== mexp()) begin failures++; $display("FAIL random step=%0d got=%h exp=%h", i, obs, mexp()); end
    end
  endtask

  initial begin
    test_reset();
    test_inc_wrap();
    test_jump_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_halt();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
